// File: rtl/sr_latch_input_conditioner.sv
// Synchronises and debounces two raw push-buttons and shapes each accepted press
// into a fixed-width, mutually exclusive active-low strobe for a NAND SR latch.
module sr_latch_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_WIDTH     = 3,
    parameter int GAP_CYCLES      = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_set,
    input  logic i_btn_reset,
    output logic o_S_n,
    output logic o_R_n,
    output logic o_set_db,
    output logic o_reset_db,
    output logic o_busy,
    output logic o_conflict
);

    localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PMAX = (PULSE_WIDTH > GAP_CYCLES) ? PULSE_WIDTH : GAP_CYCLES;
    localparam int PCW  = (PMAX > 1) ? $clog2(PMAX) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PULSE_S,
        PULSE_R,
        GAP
    } state_t;

    // Bit 0 carries the set channel, bit 1 the reset channel.
    logic [1:0]     r_sync1;
    logic [1:0]     r_sync2;
    logic [1:0]     r_db;
    logic [1:0]     r_dbPrev;
    logic [DBW-1:0] r_dbCnt [2];

    state_t         r_state;
    state_t         w_nextState;
    logic [PCW-1:0] r_pcnt;
    logic [PCW-1:0] w_nextPcnt;
    logic           r_sN;
    logic           r_rN;
    logic           w_riseSet;
    logic           w_riseReset;
    logic           w_conflict;

    // A level change is accepted only once the counter has already reached the
    // threshold and the synchronised input still disagrees with the debounced level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_db     <= '0;
            r_dbPrev <= '0;
            for (int i = 0; i < 2; i++) begin
                r_dbCnt[i] <= '0;
            end
        end else begin
            r_sync1  <= {i_btn_reset, i_btn_set};
            r_sync2  <= r_sync1;
            r_dbPrev <= r_db;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_dbCnt[i] <= '0;
                end else if (r_dbCnt[i] == DBW'(DEBOUNCE_CYCLES)) begin
                    r_db[i]    <= r_sync2[i];
                    r_dbCnt[i] <= '0;
                end else begin
                    r_dbCnt[i] <= r_dbCnt[i] + DBW'(1);
                end
            end
        end
    end

    assign w_riseSet   = r_db[0] & ~r_dbPrev[0];
    assign w_riseReset = r_db[1] & ~r_dbPrev[1];

    // Rises arriving outside IDLE are simply ignored; reset wins a simultaneous press.
    always_comb begin
        w_nextState = r_state;
        w_nextPcnt  = r_pcnt;
        w_conflict  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_riseReset) begin
                    w_nextState = PULSE_R;
                    w_nextPcnt  = PCW'(PULSE_WIDTH - 1);
                    w_conflict  = w_riseSet;
                end else if (w_riseSet) begin
                    w_nextState = PULSE_S;
                    w_nextPcnt  = PCW'(PULSE_WIDTH - 1);
                end
            end
            PULSE_S, PULSE_R: begin
                if (r_pcnt == '0) begin
                    w_nextState = GAP;
                    w_nextPcnt  = PCW'(GAP_CYCLES - 1);
                end else begin
                    w_nextPcnt = r_pcnt - PCW'(1);
                end
            end
            GAP: begin
                if (r_pcnt == '0) begin
                    w_nextState = IDLE;
                end else begin
                    w_nextPcnt = r_pcnt - PCW'(1);
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so the latch inputs never glitch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_pcnt  <= '0;
            r_sN    <= 1'b1;
            r_rN    <= 1'b1;
        end else begin
            r_state <= w_nextState;
            r_pcnt  <= w_nextPcnt;
            r_sN    <= (w_nextState != PULSE_S);
            r_rN    <= (w_nextState != PULSE_R);
        end
    end

    assign o_S_n      = r_sN;
    assign o_R_n      = r_rN;
    assign o_set_db   = r_db[0];
    assign o_reset_db = r_db[1];
    assign o_busy     = (r_state != IDLE);
    assign o_conflict = w_conflict;

endmodule

// File: tb/tb_sr_latch_input_conditioner.sv
// Bench for sr_latch_input_conditioner: a timestamp-based model of press acceptance
// and pulse windows, plus directed scenarios with hand-computed timings.
`timescale 1ns/1ps
module tb_sr_latch_input_conditioner;

    localparam int D    = 4;
    localparam int PW   = 3;
    localparam int GAP  = 2;
    localparam int HLEN = D + 3;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic btnSet   = 1'b0;
    logic btnReset = 1'b0;
    logic sN;
    logic rN;
    logic setDb;
    logic resetDb;
    logic busy;
    logic conflict;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sr_latch_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .PULSE_WIDTH    (PW),
        .GAP_CYCLES     (GAP)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_btn_set  (btnSet),
        .i_btn_reset(btnReset),
        .o_S_n      (sN),
        .o_R_n      (rN),
        .o_set_db   (setDb),
        .o_reset_db (resetDb),
        .o_busy     (busy),
        .o_conflict (conflict)
    );

    // Model state: raw sample history per button, debounced levels, and the
    // edge index at which the current pulse window started.
    bit hist [2][HLEN];
    bit mDb [2];
    bit mPrev [2];
    int mCyc      = 0;
    int mStart    = -1000;
    bit mKindR    = 1'b0;
    bit mValid    = 1'b0;
    bit mRstEdge  = 1'b0;
    bit eSn       = 1'b1;
    bit eRn       = 1'b1;
    bit eBusy     = 1'b0;
    bit eConflict = 1'b0;

    int lowRun     = 0;
    int highRun    = GAP;
    int pulseCount = 0;

    int obsIdx;
    int obsFirstS;
    int obsFirstR;
    int obsFirstConflict;
    int obsSLow;
    int obsRLow;
    int obsBusy;
    int obsConflict;
    int obsResetDb;

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // A debounced level flips once the last D+1 samples seen by the debouncer
    // (raw values delayed two edges by the synchroniser) all disagree with it.
    task automatic modelStep();
        bit raw [2];
        bit rise [2];
        bit busyBefore;
        bit flip;
        bit low;
        raw[0] = btnSet;
        raw[1] = btnReset;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < HLEN; j++) hist[i][j] = 1'b0;
                mDb[i]   = 1'b0;
                mPrev[i] = 1'b0;
            end
            mCyc     = 0;
            mStart   = -1000;
            mKindR   = 1'b0;
            mValid   = 1'b1;
            mRstEdge = 1'b1;
        end else if (mValid) begin
            mRstEdge   = 1'b0;
            mCyc++;
            busyBefore = eBusy;
            for (int i = 0; i < 2; i++) begin
                rise[i]  = mDb[i] && !mPrev[i];
                mPrev[i] = mDb[i];
                for (int j = HLEN - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
                hist[i][0] = raw[i];
                flip = 1'b1;
                for (int j = 2; j <= D + 2; j++) begin
                    if (hist[i][j] == mDb[i]) flip = 1'b0;
                end
                if (flip) mDb[i] = !mDb[i];
            end
            if (!busyBefore && (rise[0] || rise[1])) begin
                mStart = mCyc;
                mKindR = rise[1];
            end
        end
        low       = (mCyc >= mStart) && (mCyc < mStart + PW);
        eBusy     = (mCyc >= mStart) && (mCyc < mStart + PW + GAP);
        eSn       = !(low && !mKindR);
        eRn       = !(low && mKindR);
        eConflict = !eBusy && mDb[0] && !mPrev[0] && mDb[1] && !mPrev[1];
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    // Every cycle after the first reset: compare against the model, check
    // mutual exclusion, and check pulse width / spacing directly on the outputs.
    initial forever begin
        @(negedge clk);
        if (mValid) begin
            checkOutput("S_n", sN, eSn);
            checkOutput("R_n", rN, eRn);
            checkOutput("set_db", setDb, mDb[0]);
            checkOutput("reset_db", resetDb, mDb[1]);
            checkOutput("busy", busy, eBusy);
            checkOutput("conflict", conflict, eConflict);
            checkOutput("exclusive", sN | rN, 1'b1);
            if (mRstEdge) begin
                lowRun  = 0;
                highRun = GAP;
            end else if (!sN || !rN) begin
                if (lowRun == 0) begin
                    checkOutput("gapBeforePulse", highRun >= GAP, 1'b1);
                    pulseCount++;
                end
                lowRun++;
                highRun = 0;
            end else begin
                if (lowRun > 0) checkCount("pulseWidth", lowRun, PW);
                lowRun = 0;
                highRun++;
            end
        end
    end

    task automatic applyStimulus(input bit s, input bit r, input int cycles);
        btnSet   = s;
        btnReset = r;
        repeat (cycles) @(negedge clk);
    endtask

    // Index k in the recorded data is the state after the k-th edge following the call.
    task automatic observe(input int cycles, input bit fresh);
        if (fresh) begin
            obsIdx           = 0;
            obsFirstS        = -1;
            obsFirstR        = -1;
            obsFirstConflict = -1;
            obsSLow          = 0;
            obsRLow          = 0;
            obsBusy          = 0;
            obsConflict      = 0;
            obsResetDb       = 0;
        end
        repeat (cycles) begin
            @(negedge clk);
            if (!sN) begin
                obsSLow++;
                if (obsFirstS < 0) obsFirstS = obsIdx;
            end
            if (!rN) begin
                obsRLow++;
                if (obsFirstR < 0) obsFirstR = obsIdx;
            end
            if (conflict) begin
                obsConflict++;
                if (obsFirstConflict < 0) obsFirstConflict = obsIdx;
            end
            if (busy) obsBusy++;
            if (resetDb) obsResetDb++;
            obsIdx++;
        end
    endtask

    initial begin
        bit intentS;
        bit intentR;
        int randPulsesBefore;

        repeat (3) @(negedge clk);
        checkOutput("resetS_n", sN, 1'b1);
        checkOutput("resetR_n", rN, 1'b1);
        checkOutput("resetBusy", busy, 1'b0);
        checkOutput("resetSetDb", setDb, 1'b0);
        rst = 1'b0;

        $display("[TB] held set press");
        applyStimulus(1'b1, 1'b0, 0);
        observe(20, 1'b1);
        checkCount("heldFirstS", obsFirstS, 7);
        checkCount("heldSLow", obsSLow, 3);
        checkCount("heldRLow", obsRLow, 0);
        checkCount("heldBusy", obsBusy, 5);
        applyStimulus(1'b0, 1'b0, 15);

        $display("[TB] reset glitch");
        applyStimulus(1'b0, 1'b1, 0);
        observe(2, 1'b1);
        applyStimulus(1'b0, 1'b0, 0);
        observe(15, 1'b0);
        checkCount("glitchResetDb", obsResetDb, 0);
        checkCount("glitchRLow", obsRLow, 0);

        $display("[TB] simultaneous press");
        applyStimulus(1'b1, 1'b1, 0);
        observe(20, 1'b1);
        checkCount("bothFirstR", obsFirstR, 7);
        checkCount("bothRLow", obsRLow, 3);
        checkCount("bothSLow", obsSLow, 0);
        checkCount("bothConflicts", obsConflict, 1);
        checkCount("bothConflictAt", obsFirstConflict, 6);
        applyStimulus(1'b0, 1'b0, 15);

        $display("[TB] reset press during set pulse");
        applyStimulus(1'b1, 1'b0, 0);
        observe(2, 1'b1);
        applyStimulus(1'b1, 1'b1, 0);
        observe(25, 1'b0);
        checkCount("dropFirstS", obsFirstS, 7);
        checkCount("dropSLow", obsSLow, 3);
        checkCount("dropRLow", obsRLow, 0);
        applyStimulus(1'b1, 1'b0, 12);
        applyStimulus(1'b1, 1'b1, 0);
        observe(20, 1'b1);
        checkCount("repressFirstR", obsFirstR, 7);
        checkCount("repressRLow", obsRLow, 3);
        checkCount("repressSLow", obsSLow, 0);
        applyStimulus(1'b0, 1'b0, 15);

        $display("[TB] reset mid-pulse");
        applyStimulus(1'b1, 1'b0, 0);
        observe(9, 1'b1);
        checkCount("abortFirstS", obsFirstS, 7);
        checkOutput("abortPreLow", sN, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abortS_n", sN, 1'b1);
        checkOutput("abortBusy", busy, 1'b0);
        checkOutput("abortSetDb", setDb, 1'b0);
        rst = 1'b0;
        observe(20, 1'b1);
        checkCount("afterAbortFirstS", obsFirstS, 7);
        checkCount("afterAbortSLow", obsSLow, 3);
        applyStimulus(1'b0, 1'b0, 15);

        $display("[TB] random bouncing");
        intentS          = 1'b0;
        intentR          = 1'b0;
        randPulsesBefore = pulseCount;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 29) == 0) intentS = !intentS;
            if ($urandom_range(0, 29) == 0) intentR = !intentR;
            applyStimulus(intentS ^ ($urandom_range(0, 5) == 0),
                          intentR ^ ($urandom_range(0, 5) == 0), 1);
        end
        checkOutput("randomPulsesSeen", pulseCount > randPulsesBefore, 1'b1);
        applyStimulus(1'b0, 1'b0, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
